// File: rtl/iddr_deskew_pkg.sv
// Shared command encodings and control FSM state type for the DDR deskew block.
package iddr_deskew_pkg;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StVtcOff,
    StApply,
    StSettle,
    StMeasure,
    StResp
  } state_e;

endpackage

// File: rtl/iddr_capture.sv
// Single-lane DDR capture: posedge and negedge samples re-registered onto posedge.
module iddr_capture (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q1_o,
  output logic q2_o
);

  logic r1_q, r2_q, q1_q, q2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r1_q <= 1'b0;
      q1_q <= 1'b0;
      q2_q <= 1'b0;
    end else begin
      r1_q <= d_i;
      q1_q <= r1_q;
      q2_q <= r2_q;
    end
  end

  // Falling-edge half of the bit period; reset is sampled on this edge too.
  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      r2_q <= 1'b0;
    end else begin
      r2_q <= d_i;
    end
  end

  assign q1_o = q1_q;
  assign q2_o = q2_q;

endmodule

// File: rtl/iddr_deskew.sv
// Multi-lane DDR capture with per-lane delay-tap command FSM.
// Optional transition monitor enabled by defining IDDR_DESKEW_MONITOR_EN.
module iddr_deskew
  import iddr_deskew_pkg::*;
#(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned LANE_BITS     = 2,
  parameter int unsigned TAP_BITS      = 9,
  parameter int unsigned TAP_MAX       = 511,
  parameter int unsigned INIT_TAP      = 0,
  parameter int unsigned VTC_CYCLES    = 8,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned MON_BITS      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          d,
  output logic [WIDTH-1:0]          q1,
  output logic [WIDTH-1:0]          q2,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [LANE_BITS-1:0]      cmd_lane,
  input  logic [1:0]                cmd_op,
  input  logic [TAP_BITS-1:0]       cmd_value,
  output logic                      rsp_valid,
  output logic [TAP_BITS-1:0]       rsp_tap,
  output logic                      rsp_sat,
  output logic                      rsp_err,
  output logic [MON_BITS:0]         rsp_count,
  output logic [WIDTH*TAP_BITS-1:0] tap_out,
  output logic [WIDTH-1:0]          tap_ce,
  output logic                      tap_inc,
  output logic [WIDTH-1:0]          tap_load,
  output logic                      en_vtc
);

  localparam logic [TAP_BITS-1:0] TapMax  = TAP_BITS'(TAP_MAX);
  localparam logic [TAP_BITS-1:0] TapInit = TAP_BITS'(INIT_TAP);

  for (genvar n = 0; n < WIDTH; n++) begin : g_lane
    iddr_capture u_cap (
      .clk_i (clk),
      .rst_i (rst),
      .d_i   (d[n]),
      .q1_o  (q1[n]),
      .q2_o  (q2[n])
    );
  end

  state_e                state_q, state_d;
  int unsigned           timer_q, timer_d;
  logic [LANE_BITS-1:0]  lane_q;
  logic [1:0]            op_q;
  logic [TAP_BITS-1:0]   value_q;
  logic                  err_q, sat_q, inc_q;
  logic [WIDTH-1:0]      ce_q, load_q;
  logic [TAP_BITS-1:0]   tap_q [WIDTH];
  logic                  accept, lane_bad;

  assign cmd_ready = (state_q == StIdle) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign lane_bad  = 32'(cmd_lane) >= WIDTH;

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q  <= '0;
      op_q    <= OP_READ;
      value_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      lane_q  <= cmd_lane;
      op_q    <= cmd_op;
      value_q <= cmd_value;
      err_q   <= lane_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      timer_q <= 0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (cmd_op == OP_READ || lane_bad) begin
            state_d = StResp;
          end else begin
            state_d = StVtcOff;
            timer_d = VTC_CYCLES - 1;
          end
        end
      end
      StVtcOff: begin
        if (timer_q == 0) state_d = StApply;
        else timer_d = timer_q - 1;
      end
      StApply: begin
        state_d = StSettle;
        timer_d = SETTLE_CYCLES - 1;
      end
      StSettle: begin
        if (timer_q == 0) begin
`ifdef IDDR_DESKEW_MONITOR_EN
          state_d = StMeasure;
          timer_d = (1 << MON_BITS) - 1;
`else
          state_d = StResp;
`endif
        end else begin
          timer_d = timer_q - 1;
        end
      end
      StMeasure: begin
        if (timer_q == 0) state_d = StResp;
        else timer_d = timer_q - 1;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Taps and strobes change together on the edge leaving APPLY.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < WIDTH; n++) tap_q[n] <= TapInit;
      ce_q   <= '0;
      load_q <= '0;
      inc_q  <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      ce_q   <= '0;
      load_q <= '0;
      if (accept) sat_q <= 1'b0;
      if (state_q == StApply) begin
        case (op_q)
          OP_INC: begin
            inc_q <= 1'b1;
            if (tap_q[lane_q] < TapMax) begin
              tap_q[lane_q] <= tap_q[lane_q] + TAP_BITS'(1);
              ce_q[lane_q]  <= 1'b1;
            end else begin
              sat_q <= 1'b1;
            end
          end
          OP_DEC: begin
            inc_q <= 1'b0;
            if (tap_q[lane_q] != '0) begin
              tap_q[lane_q] <= tap_q[lane_q] - TAP_BITS'(1);
              ce_q[lane_q]  <= 1'b1;
            end else begin
              sat_q <= 1'b1;
            end
          end
          OP_LOAD: begin
            load_q[lane_q] <= 1'b1;
            if (value_q > TapMax) begin
              tap_q[lane_q] <= TapMax;
              sat_q         <= 1'b1;
            end else begin
              tap_q[lane_q] <= value_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar n = 0; n < WIDTH; n++) begin : g_tap
    assign tap_out[n*TAP_BITS +: TAP_BITS] = tap_q[n];
  end

  assign tap_ce    = ce_q;
  assign tap_load  = load_q;
  assign tap_inc   = inc_q;
  assign en_vtc    = !(state_q inside {StVtcOff, StApply, StSettle, StMeasure});
  assign rsp_valid = (state_q == StResp);
  assign rsp_sat   = rsp_valid && sat_q;
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_tap   = (rsp_valid && !err_q) ? tap_q[lane_q] : '0;

`ifdef IDDR_DESKEW_MONITOR_EN
  logic [MON_BITS:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      count_q <= '0;
    end else if (state_q == StMeasure && (q1[lane_q] != q2[lane_q]) && (count_q != '1)) begin
      count_q <= count_q + (MON_BITS + 1)'(1);
    end
  end

  assign rsp_count = rsp_valid ? count_q : '0;
`else
  assign rsp_count = '0;
`endif

endmodule

// File: tb/tb_iddr_deskew.sv
// Randomized self-checking bench for iddr_deskew against a tap-arithmetic reference model.
module tb_iddr_deskew;

  localparam int W    = 3;
  localparam int LB   = 2;
  localparam int TB   = 10;
  localparam int TMAX = 511;
  localparam int INIT = 16;
  localparam int VTC  = 8;
  localparam int SET  = 4;
  localparam int MB   = 8;
`ifdef IDDR_DESKEW_MONITOR_EN
  localparam int MONW = 1 << MB;
`else
  localparam int MONW = 0;
`endif
  localparam int LAT_STEP = VTC + 1 + SET + 1 + MONW;
  localparam int VTC_LOW  = VTC + 1 + SET + MONW;

  logic            clk, rst;
  logic [W-1:0]    d, q1, q2;
  logic            cmd_valid, cmd_ready;
  logic [LB-1:0]   cmd_lane;
  logic [1:0]      cmd_op;
  logic [TB-1:0]   cmd_value;
  logic            rsp_valid, rsp_sat, rsp_err, tap_inc, en_vtc;
  logic [TB-1:0]   rsp_tap;
  logic [MB:0]     rsp_count;
  logic [W*TB-1:0] tap_out;
  logic [W-1:0]    tap_ce, tap_load;

  logic [W-1:0] d_rise = '0;
  logic [W-1:0] d_fall = '0;
  int total = 0;
  int bad   = 0;
  int model_tap [W];

  iddr_deskew #(
    .WIDTH(W), .LANE_BITS(LB), .TAP_BITS(TB), .TAP_MAX(TMAX), .INIT_TAP(INIT),
    .VTC_CYCLES(VTC), .SETTLE_CYCLES(SET), .MON_BITS(MB)
  ) dut (
    .clk(clk), .rst(rst), .d(d), .q1(q1), .q2(q2),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_lane(cmd_lane), .cmd_op(cmd_op),
    .cmd_value(cmd_value), .rsp_valid(rsp_valid), .rsp_tap(rsp_tap), .rsp_sat(rsp_sat),
    .rsp_err(rsp_err), .rsp_count(rsp_count), .tap_out(tap_out), .tap_ce(tap_ce),
    .tap_inc(tap_inc), .tap_load(tap_load), .en_vtc(en_vtc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // d carries d_rise into each posedge and d_fall into each negedge.
  initial begin
    d = '0;
    forever begin
      @(negedge clk); #2 d = d_rise;
      @(posedge clk); #2 d = d_fall;
    end
  end

  function automatic int lane_tap(input int lane);
    return int'(tap_out[lane*TB +: TB]);
  endfunction

  task automatic do_cmd(input logic [1:0] op, input int lane, input int value,
                        output int o_tap, output int o_sat, output int o_err, output int o_cnt,
                        output int o_lat, output int o_vtc_low, output int o_ce_n,
                        output logic [W-1:0] o_ce_mask, output int o_ld_n,
                        output logic [W-1:0] o_ld_mask, output logic o_inc, output int o_rdy_n);
    int waitc;
    o_tap = 0; o_sat = 0; o_err = 0; o_cnt = 0; o_lat = -1; o_vtc_low = 0;
    o_ce_n = 0; o_ce_mask = '0; o_ld_n = 0; o_ld_mask = '0; o_inc = 1'b0; o_rdy_n = 0;
    waitc = 0;
    while (!cmd_ready && waitc < 100) begin
      @(posedge clk); #1;
      waitc++;
    end
    cmd_valid = 1'b1;
    cmd_lane  = LB'(lane);
    cmd_op    = op;
    cmd_value = TB'(value);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int n = 1; n <= 2000; n++) begin
      if (!en_vtc) o_vtc_low++;
      if (tap_ce != '0) begin
        o_ce_n++;
        o_ce_mask |= tap_ce;
        o_inc = tap_inc;
      end
      if (tap_load != '0) begin
        o_ld_n++;
        o_ld_mask |= tap_load;
      end
      if (rsp_valid) begin
        o_lat = n; o_tap = int'(rsp_tap); o_sat = int'(rsp_sat);
        o_err = int'(rsp_err); o_cnt = int'(rsp_count);
        break;
      end
      if (cmd_ready) o_rdy_n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_lane = '0; cmd_op = 2'b00; cmd_value = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int l = 0; l < W; l++) begin
      total++;
      if (lane_tap(l) !== INIT) begin
        bad++; $display("FAIL reset_tap%0d got=%0d want=%0d", l, lane_tap(l), INIT);
      end
    end
    total++;
    if (en_vtc !== 1'b1) begin bad++; $display("FAIL reset_en_vtc got=%b want=1", en_vtc); end
    total++;
    if ({tap_ce, tap_load, rsp_valid, rsp_sat, rsp_err, rsp_tap, rsp_count, q1, q2} !== '0) begin
      bad++; $display("FAIL reset_outputs got=nonzero want=0 (ce=%b ld=%b rv=%b q1=%b q2=%b)",
                      tap_ce, tap_load, rsp_valid, q1, q2);
    end
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_in_rst got=%b want=0", cmd_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b want=1", cmd_ready); end
    for (int l = 0; l < W; l++) model_tap[l] = INIT;
  endtask

  task automatic test_capture();
    logic [W-1:0] old_r;
    d_rise = 3'b001; d_fall = 3'b000;
    repeat (3) begin @(posedge clk); #1; end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (q1 !== 3'b001 || q2 !== 3'b000) begin
        bad++; $display("FAIL ddr_alt q1=%b q2=%b want q1=001 q2=000", q1, q2);
      end
      @(posedge clk); #1;
    end
    // Rising-edge latency: new value invisible after one edge, present after two.
    old_r = d_rise;
    d_rise = 3'b110;
    @(posedge clk); #1;
    total++;
    if (q1 !== old_r) begin bad++; $display("FAIL cap_lat1 got=%b want=%b", q1, old_r); end
    @(posedge clk); #1;
    total++;
    if (q1 !== 3'b110) begin bad++; $display("FAIL cap_lat2 got=%b want=110", q1); end
    for (int i = 0; i < 6; i++) begin
      d_rise = W'($urandom); d_fall = W'($urandom);
      repeat (3) begin @(posedge clk); #1; end
      total++;
      if (q1 !== d_rise || q2 !== d_fall) begin
        bad++; $display("FAIL cap_rand q1=%b q2=%b want %b %b", q1, q2, d_rise, d_fall);
      end
    end
    d_rise = '0; d_fall = '0;
  endtask

  task automatic test_inc_sat();
    int tap, sat, err, cnt, lat, vl, cen, ldn, rdy;
    logic [W-1:0] cem, ldm;
    logic inc;
    do_cmd(2'b11, 2, 510, tap, sat, err, cnt, lat, vl, cen, cem, ldn, ldm, inc, rdy);
    model_tap[2] = 510;
    total++;
    if (tap !== 510 || sat !== 0 || ldm !== 3'b100) begin
      bad++; $display("FAIL load510 tap=%0d sat=%0d ld=%b want 510 0 100", tap, sat, ldm);
    end
    do_cmd(2'b01, 2, 0, tap, sat, err, cnt, lat, vl, cen, cem, ldn, ldm, inc, rdy);
    model_tap[2] = 511;
    total++;
    if (tap !== 511 || sat !== 0) begin bad++; $display("FAIL inc1 tap=%0d sat=%0d want 511 0", tap, sat); end
    total++;
    if (cen !== 1 || cem !== 3'b100 || inc !== 1'b1) begin
      bad++; $display("FAIL inc1_ce n=%0d mask=%b inc=%b want 1 100 1", cen, cem, inc);
    end
    total++;
    if (vl !== VTC_LOW || lat !== LAT_STEP || rdy !== 0) begin
      bad++; $display("FAIL inc1_timing vtc_low=%0d lat=%0d rdy=%0d want %0d %0d 0", vl, lat, rdy,
                      VTC_LOW, LAT_STEP);
    end
    total++;
    if (lane_tap(2) !== 511) begin bad++; $display("FAIL inc1_tapout got=%0d want=511", lane_tap(2)); end
    do_cmd(2'b01, 2, 0, tap, sat, err, cnt, lat, vl, cen, cem, ldn, ldm, inc, rdy);
    total++;
    if (tap !== 511 || sat !== 1 || cen !== 0 || vl !== VTC_LOW) begin
      bad++; $display("FAIL inc2_sat tap=%0d sat=%0d ce=%0d vtc_low=%0d want 511 1 0 %0d",
                      tap, sat, cen, vl, VTC_LOW);
    end
  endtask

  task automatic test_load_dec();
    int tap, sat, err, cnt, lat, vl, cen, ldn, rdy;
    logic [W-1:0] cem, ldm;
    logic inc;
    do_cmd(2'b11, 1, 600, tap, sat, err, cnt, lat, vl, cen, cem, ldn, ldm, inc, rdy);
    model_tap[1] = 511;
    total++;
    if (tap !== 511 || sat !== 1 || ldn !== 1 || ldm !== 3'b010 || lane_tap(1) !== 511) begin
      bad++; $display("FAIL load600 tap=%0d sat=%0d ldn=%0d ldm=%b want 511 1 1 010",
                      tap, sat, ldn, ldm);
    end
    do_cmd(2'b11, 0, 0, tap, sat, err, cnt, lat, vl, cen, cem, ldn, ldm, inc, rdy);
    model_tap[0] = 0;
    do_cmd(2'b10, 0, 0, tap, sat, err, cnt, lat, vl, cen, cem, ldn, ldm, inc, rdy);
    total++;
    if (tap !== 0 || sat !== 1 || cen !== 0 || ldn !== 0) begin
      bad++; $display("FAIL dec_zero tap=%0d sat=%0d ce=%0d ld=%0d want 0 1 0 0", tap, sat, cen, ldn);
    end
    do_cmd(2'b10, 1, 0, tap, sat, err, cnt, lat, vl, cen, cem, ldn, ldm, inc, rdy);
    model_tap[1] = 510;
    total++;
    if (tap !== 510 || sat !== 0 || cem !== 3'b010 || inc !== 1'b0) begin
      bad++; $display("FAIL dec_step tap=%0d sat=%0d ce=%b inc=%b want 510 0 010 0", tap, sat, cem, inc);
    end
  endtask

  task automatic test_bad_lane();
    int tap, sat, err, cnt, lat, vl, cen, ldn, rdy;
    logic [W-1:0] cem, ldm;
    logic inc;
    logic [W*TB-1:0] snap;
    snap = tap_out;
    do_cmd(2'b01, 3, 0, tap, sat, err, cnt, lat, vl, cen, cem, ldn, ldm, inc, rdy);
    total++;
    if (err !== 1 || lat !== 1 || tap !== 0 || cen !== 0 || ldn !== 0 || vl !== 0) begin
      bad++; $display("FAIL bad_lane err=%0d lat=%0d tap=%0d ce=%0d ld=%0d vl=%0d want 1 1 0 0 0 0",
                      err, lat, tap, cen, ldn, vl);
    end
    total++;
    if (tap_out !== snap) begin bad++; $display("FAIL bad_lane_taps got=%h want=%h", tap_out, snap); end
    do_cmd(2'b00, 1, 0, tap, sat, err, cnt, lat, vl, cen, cem, ldn, ldm, inc, rdy);
    total++;
    if (tap !== model_tap[1] || lat !== 1 || err !== 0 || vl !== 0) begin
      bad++; $display("FAIL read tap=%0d lat=%0d err=%0d want %0d 1 0", tap, lat, err, model_tap[1]);
    end
  endtask

  task automatic test_random();
    int tap, sat, err, cnt, lat, vl, cen, ldn, rdy;
    int lane, val, e_tap, e_sat, e_err, e_lat, e_ce, e_ld;
    logic [1:0] op;
    logic [W-1:0] cem, ldm;
    logic inc;
    d_rise = W'($urandom); d_fall = d_rise;
    for (int i = 0; i < 25; i++) begin
      lane = $urandom_range(0, 3);
      op   = 2'($urandom_range(0, 3));
      val  = $urandom_range(0, 1023);
      e_sat = 0; e_err = 0; e_ce = 0; e_ld = 0; e_lat = LAT_STEP;
      if (lane >= W) begin
        e_err = 1; e_tap = 0; e_lat = 1;
      end else begin
        case (op)
          2'b00: e_lat = 1;
          2'b01: if (model_tap[lane] < TMAX) begin model_tap[lane]++; e_ce = 1; end else e_sat = 1;
          2'b10: if (model_tap[lane] > 0) begin model_tap[lane]--; e_ce = 1; end else e_sat = 1;
          default: begin
            e_ld = 1;
            e_sat = (val > TMAX) ? 1 : 0;
            model_tap[lane] = (val > TMAX) ? TMAX : val;
          end
        endcase
        e_tap = model_tap[lane];
      end
      do_cmd(op, lane, val, tap, sat, err, cnt, lat, vl, cen, cem, ldn, ldm, inc, rdy);
      total++;
      if (tap !== e_tap || sat !== e_sat || err !== e_err || lat !== e_lat || cnt !== 0) begin
        bad++; $display("FAIL rand%0d op=%0d lane=%0d tap=%0d sat=%0d err=%0d lat=%0d cnt=%0d want %0d %0d %0d %0d 0",
                        i, op, lane, tap, sat, err, lat, cnt, e_tap, e_sat, e_err, e_lat);
      end
      total++;
      if (cen !== e_ce || ldn !== e_ld || rdy !== 0) begin
        bad++; $display("FAIL rand%0d_strobe ce=%0d ld=%0d rdy=%0d want %0d %0d 0", i, cen, ldn, rdy, e_ce, e_ld);
      end
      @(posedge clk); #1;
      total++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        bad++; $display("FAIL rand%0d_after rv=%b rdy=%b want 0 1", i, rsp_valid, cmd_ready);
      end
      for (int l = 0; l < W; l++) begin
        total++;
        if (lane_tap(l) !== model_tap[l]) begin
          bad++; $display("FAIL rand%0d_tap%0d got=%0d want=%0d", i, l, lane_tap(l), model_tap[l]);
        end
      end
    end
    d_rise = '0; d_fall = '0;
  endtask

`ifdef IDDR_DESKEW_MONITOR_EN
  task automatic test_monitor();
    int tap, sat, err, cnt, lat, vl, cen, ldn, rdy;
    logic [W-1:0] cem, ldm;
    logic inc;
    d_rise = 3'b001; d_fall = 3'b000;
    do_cmd(2'b11, 0, 5, tap, sat, err, cnt, lat, vl, cen, cem, ldn, ldm, inc, rdy);
    model_tap[0] = 5;
    total++;
    if (cnt !== (1 << MB) || lat !== LAT_STEP) begin
      bad++; $display("FAIL monitor cnt=%0d lat=%0d want %0d %0d", cnt, lat, 1 << MB, LAT_STEP);
    end
    d_rise = '0;
  endtask
`endif

  task automatic test_reset_mid();
    int rv, waitc;
    waitc = 0;
    while (!cmd_ready && waitc < 100) begin @(posedge clk); #1; waitc++; end
    cmd_valid = 1'b1; cmd_lane = 2'd0; cmd_op = 2'b11; cmd_value = TB'(100);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (VTC + 1 + 2) begin @(posedge clk); #1; end
    total++;
    if (lane_tap(0) !== 100 || en_vtc !== 1'b0) begin
      bad++; $display("FAIL mid_settle tap=%0d en_vtc=%b want 100 0", lane_tap(0), en_vtc);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rv = 0;
    for (int n = 0; n < 400; n++) begin
      if (rsp_valid) rv++;
      @(posedge clk); #1;
    end
    total++;
    if (rv !== 0) begin bad++; $display("FAIL mid_no_rsp got=%0d want=0", rv); end
    for (int l = 0; l < W; l++) begin
      model_tap[l] = INIT;
      total++;
      if (lane_tap(l) !== INIT) begin
        bad++; $display("FAIL mid_tap%0d got=%0d want=%0d", l, lane_tap(l), INIT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_inc_sat();
    test_load_dec();
    test_bad_lane();
    test_random();
`ifdef IDDR_DESKEW_MONITOR_EN
    test_monitor();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iddr_deskew.md
# iddr_deskew

Multi-lane source-synchronous DDR input capture with a per-lane delay-tap controller. Each lane captures rising- and falling-edge data onto `clk`. A command FSM tracks the tap setting of each lane and drives the external variable delay elements (CE/INC/LOAD, VTC hold). Training software uses it to sweep and centre each lane's sampling point. It sits between the pad/delay primitives and the MAC-side RGMII/parallel receive logic.

## Interface
Parameters:
- `WIDTH`, 4: number of lanes.
- `LANE_BITS`, 2: width of the lane index; 2^LANE_BITS ≥ WIDTH.
- `TAP_BITS`, 9: width of the tap count.
- `TAP_MAX`, 511: highest legal tap.
- `INIT_TAP`, 0: tap value after reset.
- `VTC_CYCLES`, 8: cycles that `en_vtc` is held low before a tap change.
- `SETTLE_CYCLES`, 4: cycles after a tap change before the response.
- `MON_BITS`, 8: monitor window is 2^MON_BITS cycles; counter width is MON_BITS+1.

Ports:
- `clk` in 1: single clock. Captures on both edges; all control logic is posedge.
- `rst` in 1: synchronous, active-high reset.
- `d` in WIDTH: delayed lane data from the delay elements.
- `q1` out WIDTH: rising-edge sample.
- `q2` out WIDTH: falling-edge sample of the same bit period.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when both `cmd_valid` and `cmd_ready` are high.
- `cmd_lane` in LANE_BITS: target lane.
- `cmd_op` in 2: 00 READ, 01 INC, 10 DEC, 11 LOAD.
- `cmd_value` in TAP_BITS: LOAD value.
- `rsp_valid` out 1: single-cycle response pulse.
- `rsp_tap` out TAP_BITS: lane tap after the command.
- `rsp_sat` out 1: command clipped by a limit.
- `rsp_err` out 1: lane index ≥ WIDTH.
- `rsp_count` out MON_BITS+1: monitor result.
- `tap_out` out WIDTH*TAP_BITS: current tap per lane. Lane n occupies bits [n*TAP_BITS +: TAP_BITS].
- `tap_ce` out WIDTH: one-cycle step enable.
- `tap_inc` out 1: step direction, 1 = increment.
- `tap_load` out WIDTH: one-cycle load strobe.
- `en_vtc` out 1: low while a tap change is in progress.

## Operation
- Capture path, per lane:
  - `d` is registered on posedge into r1 and on negedge into r2.
  - Both are re-registered on posedge into `q1`/`q2`.
- FSM states: IDLE, VTC_OFF, APPLY, SETTLE, MEASURE, RESP.
- IDLE:
  - `cmd_ready` is 1.
  - On accept, the command is latched.
  - READ, or any command with a bad lane, goes to RESP.
  - Otherwise go to VTC_OFF.
- VTC_OFF: `en_vtc` is 0 for VTC_CYCLES cycles, then go to APPLY.
- APPLY, one cycle:
  - INC: if tap < TAP_MAX, tap+1, `tap_ce[lane]`=1, `tap_inc`=1. Otherwise sat=1 and no strobe.
  - DEC: if tap > 0, tap−1, `tap_ce[lane]`=1, `tap_inc`=0. Otherwise sat=1 and no strobe.
  - LOAD: tap = min(`cmd_value`, TAP_MAX), `tap_load[lane]`=1. sat=1 if the value was clamped.
- SETTLE: wait SETTLE_CYCLES cycles, then go to MEASURE if the monitor is compiled in, else RESP.
- RESP:
  - `rsp_valid`=1 for one cycle and `en_vtc` returns to 1.
  - `rsp_tap`/`rsp_sat`/`rsp_err`/`rsp_count` are valid only while `rsp_valid` is 1.
  - Next state is IDLE.
- Bad lane: no tap change, no strobes, `rsp_tap`=0, `rsp_err`=1.
- Reset values:
  - `q1`/`q2`/r1/r2 = 0.
  - Every tap = INIT_TAP.
  - `tap_ce`/`tap_load`/`rsp_*` = 0.
  - `en_vtc`=1, `cmd_ready`=0.
  - State = IDLE.
- Reset mid-command: the command is aborted with no response, and taps revert to INIT_TAP. Software must re-LOAD the delay elements after reset.

## Timing
- Capture latency: data sampled at posedge k appears on `q1` after posedge k+1. Data sampled at the negedge between k and k+1 appears on `q2` after posedge k+1. Both are aligned to the same bit period.
- `cmd_ready` is 1 in the first cycle after reset deasserts.
- Latency from accept edge to `rsp_valid`:
  - INC/DEC/LOAD: VTC_CYCLES+1+SETTLE_CYCLES+1 cycles, plus 2^MON_BITS with the monitor compiled in.
  - READ or bad lane: 1 cycle.
- `cmd_ready` is 0 from the accept edge until the cycle after RESP. There is no back-to-back acceptance.
- `tap_out` updates on the same edge that raises `tap_ce`/`tap_load`.

## Configuration
- Macro `IDDR_DESKEW_MONITOR_EN`.
- When defined:
  - A MEASURE state of 2^MON_BITS cycles follows SETTLE.
  - It counts cycles where `q1[lane] != q2[lane]` on the commanded lane.
  - The counter saturates at 2^(MON_BITS+1)−1.
  - The result is returned on `rsp_count`.
- When undefined: MEASURE is never entered, `rsp_count` is tied to 0, and no counter logic exists.

## Structure
- Package `iddr_deskew_pkg`:
  - `cmd_op` encodings (OP_READ/OP_INC/OP_DEC/OP_LOAD).
  - FSM state enum.
- Sub-module `iddr_capture`: per-lane posedge/negedge capture plus re-registration, instantiated WIDTH times.
- The FSM and tap registers live in the top level.

## Test plan
- Reset: assert `rst` 1 cycle with INIT_TAP=16, then release.
  - `tap_out` shows all lanes = 16, `en_vtc`=1, outputs = 0, `cmd_ready`=1 next cycle.
- DDR capture: drive alternating bits 1/0 on both edges of lane 0.
  - `q1`=1 and `q2`=0 every cycle after a 2-cycle latency.
- INC lane 2 from tap 510 twice:
  - First response: `rsp_tap`=511, `rsp_sat`=0, one `tap_ce[2]` pulse.
  - Second response: `rsp_tap`=511, `rsp_sat`=1, no `tap_ce`.
  - `en_vtc` is low exactly VTC_CYCLES+1+SETTLE_CYCLES cycles each.
- LOAD 600 on lane 1: `tap_load[1]` pulse, `rsp_tap`=511, `rsp_sat`=1. DEC at tap 0 gives `rsp_sat`=1 and no strobe.
- With WIDTH=3, command lane 3: `rsp_err`=1 one cycle after accept, no strobes, all taps unchanged.
- Assert `rst` during SETTLE of a LOAD 100: no `rsp_valid`, taps return to INIT_TAP. With `IDDR_DESKEW_MONITOR_EN`, toggling lane data gives `rsp_count`=256 for MON_BITS=8.
